pc_unit: RTL and testbench

//   Parametrised program-counter unit for the fetch stage of the single-cycle RISC-V core.
//   - Selects next PC from: sequential (+STEP), branch, jump, return-address stack (RAS) pop, or trap vector.
//   - Supports stall, synchronous reset to a configurable vector, and target-alignment checking.
//   - Feeds the instruction memory address; redirect inputs come from the execute/decode stages.

---
 rtl/pc_unit.sv | 174 +++++++++++++++++
 tb/tb_pc_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the fetch stage of the single-cycle RISC-V core.
//
// Chooses the next fetch address from trap vector, return-address-stack pop, jump,
// branch, hold (stall) or sequential increment, in that priority order. Redirect
// targets are alignment-checked; a bad target or a return with an empty stack sends
// the PC to TRAP_VEC and raises a one-cycle status pulse.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high
//   stall          in   hold PC when no redirect is requested
//   branch_taken   in   take branch_target
//   branch_target  in   branch destination
//   jump_valid     in   take jump_target
//   jump_target    in   jump destination
//   call           in   with jump_valid (or ret): push pc+STEP on the RAS
//   ret            in   pop RAS top and use it as next PC
//   trap           in   force PC to TRAP_VEC
//   pc             out  current fetch address
//   pc_valid       out  pc holds a fetchable address
//   misaligned     out  one-cycle pulse, selected target failed alignment
//   ras_underflow  out  one-cycle pulse, ret with empty RAS
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
module pc_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     STEP       = 4,
   parameter logic [XLEN-1:0] RESET_VEC  = '0,
   parameter logic [XLEN-1:0] TRAP_VEC   = 'h100,
   parameter int unsigned     RAS_DEPTH  = 4,   // power of two, >= 2
   parameter int unsigned     ALIGN_BITS = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_target,
   input  logic            call,
   input  logic            ret,
   input  logic            trap,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            misaligned,
   output logic            ras_underflow,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

   typedef enum logic [2:0] {
      SRC_HOLD,
      SRC_SEQ,
      SRC_TARGET,
      SRC_TRAP_VEC
   } src_e;

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_wp;      // next free slot; top entry sits at ras_wp-1
   logic [CW-1:0]   ras_count;

   logic [XLEN-1:0] pc_plus;
   logic [PW-1:0]   top_idx;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] target;
   src_e            src;
   logic [XLEN-1:0] pc_next;
   logic            push;
   logic            pop;
   logic            mis_next;
   logic            unf_next;

   assign pc_plus = pc + XLEN'(STEP);
   assign top_idx = ras_wp - PW'(1);
   assign ras_top = ras_mem[top_idx];

   always_comb begin
      src      = SRC_SEQ;
      target   = '0;
      push     = 1'b0;
      pop      = 1'b0;
      mis_next = 1'b0;
      unf_next = 1'b0;
      if (trap) begin
         src = SRC_TRAP_VEC;
      end else if (ret) begin
         if (ras_count == '0) begin
            src      = SRC_TRAP_VEC;
            unf_next = 1'b1;
         end else if ((ras_top & ALIGN_MASK) != '0) begin
            src      = SRC_TRAP_VEC;
            mis_next = 1'b1;
         end else begin
            src    = SRC_TARGET;
            target = ras_top;
            pop    = 1'b1;
            push   = call;
         end
      end else if (jump_valid) begin
         if ((jump_target & ALIGN_MASK) != '0) begin
            src      = SRC_TRAP_VEC;
            mis_next = 1'b1;
         end else begin
            src    = SRC_TARGET;
            target = jump_target;
            push   = call;
         end
      end else if (branch_taken) begin
         if ((branch_target & ALIGN_MASK) != '0) begin
            src      = SRC_TRAP_VEC;
            mis_next = 1'b1;
         end else begin
            src    = SRC_TARGET;
            target = branch_target;
         end
      end else if (stall) begin
         src = SRC_HOLD;
      end
   end

   always_comb begin
      pc_next = pc_plus;
      unique case (src)
         SRC_HOLD:     pc_next = pc;
         SRC_SEQ:      pc_next = pc_plus;
         SRC_TARGET:   pc_next = target;
         SRC_TRAP_VEC: pc_next = TRAP_VEC;
         default:      pc_next = pc_plus;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_VEC;
         pc_valid      <= 1'b0;
         misaligned    <= 1'b0;
         ras_underflow <= 1'b0;
         ras_wp        <= '0;
         ras_count     <= '0;
      end else begin
         pc            <= pc_next;
         pc_valid      <= 1'b1;
         misaligned    <= mis_next;
         ras_underflow <= unf_next;
         // Pop+push in one cycle replaces the top in place: pointer and count unchanged.
         if (pop && !push) begin
            ras_wp    <= ras_wp - PW'(1);
            ras_count <= ras_count - CW'(1);
         end else if (push && !pop) begin
            // Circular buffer: a push when full overwrites the oldest entry.
            ras_wp <= ras_wp + PW'(1);
            if (ras_count != CW'(RAS_DEPTH))
               ras_count <= ras_count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         if (pop)
            ras_mem[top_idx] <= pc_plus;
         else
            ras_mem[ras_wp] <= pc_plus;
      end
   end

   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == CW'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        call;
   logic        ret;
   logic        trap;
   logic [31:0] pc;
   logic        pc_valid;
   logic        misaligned;
   logic        ras_underflow;
   logic        ras_empty;
   logic        ras_full;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   pc_unit #(
      .XLEN(32), .STEP(4), .RESET_VEC(32'h0), .TRAP_VEC(32'h100),
      .RAS_DEPTH(4), .ALIGN_BITS(2)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .call(call), .ret(ret), .trap(trap),
      .pc(pc), .pc_valid(pc_valid), .misaligned(misaligned),
      .ras_underflow(ras_underflow), .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // pc plus the two status pulses and the empty flag
   task automatic st(input string tag, input logic [31:0] epc, input logic emis,
                     input logic eunf, input logic eempty);
      chk({tag, ".pc"}, pc, epc);
      chk({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, emis});
      chk({tag, ".ras_underflow"}, {31'b0, ras_underflow}, {31'b0, eunf});
      chk({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, eempty});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; branch_taken = 0; branch_target = '0; jump_valid = 0;
      jump_target = '0; call = 0; ret = 0; trap = 0;
   endtask

   initial begin
      idle();
      reset = 1;

      // reset state
      step();
      st("rst1", 32'h0, 0, 0, 1);
      chk("rst1.pc_valid", {31'b0, pc_valid}, 32'd0);
      chk("rst1.ras_full", {31'b0, ras_full}, 32'd0);
      step();
      chk("rst2.pc", pc, 32'h0);
      chk("rst2.pc_valid", {31'b0, pc_valid}, 32'd0);

      // free run
      reset = 0;
      step();
      chk("seq1.pc", pc, 32'h4);
      chk("seq1.pc_valid", {31'b0, pc_valid}, 32'd1);
      step();
      chk("seq2.pc", pc, 32'h8);
      step();
      chk("seq3.pc", pc, 32'hC);

      // stall, then branch while stalled
      stall = 1;
      branch_taken = 1; branch_target = 32'h8;
      step();
      chk("br_to8.pc", pc, 32'h8);
      branch_taken = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall.pc", pc, 32'h8);
      end
      branch_taken = 1; branch_target = 32'h40;
      step();
      st("br_stalled", 32'h40, 0, 0, 1);
      idle();
      step();
      chk("after_br.pc", pc, 32'h44);

      // call to 0x200 from 0x10, return from 0x208
      branch_taken = 1; branch_target = 32'h10;
      step();
      chk("br_to10.pc", pc, 32'h10);
      idle();
      jump_valid = 1; call = 1; jump_target = 32'h200;
      step();
      st("call200", 32'h200, 0, 0, 0);
      idle();
      step();
      step();
      chk("seq208.pc", pc, 32'h208);
      ret = 1;
      step();
      st("ret14", 32'h14, 0, 0, 1);
      idle();

      // five nested calls into a 4-deep RAS; pushes 0x18,0x304,0x404,0x504,0x604
      for (int i = 0; i < 5; i++) begin
         jump_valid = 1; call = 1; jump_target = 32'h300 + 32'(i) * 32'h100;
         step();
         chk("ncall.pc", pc, 32'h300 + 32'(i) * 32'h100);
         chk("ncall.ras_full", {31'b0, ras_full}, (i >= 3) ? 32'd1 : 32'd0);
      end
      idle();
      ret = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         st("nret", 32'h604 - 32'(i) * 32'h100, 0, 0, (i == 3));
      end
      step();
      st("ret_underflow", 32'h100, 0, 1, 1);
      idle();
      step();
      st("after_unf", 32'h104, 0, 0, 1);

      // misaligned jump with call: trap vector, no push
      jump_valid = 1; call = 1; jump_target = 32'h800;
      step();
      st("call800", 32'h800, 0, 0, 0);
      jump_target = 32'h902;
      step();
      st("jmp_mis", 32'h100, 1, 0, 0);
      idle();
      step();
      st("after_mis", 32'h104, 0, 0, 0);
      ret = 1;
      step();
      st("ret108", 32'h108, 0, 0, 1);
      idle();
      branch_taken = 1; branch_target = 32'h41;
      step();
      st("br_mis", 32'h100, 1, 0, 1);
      idle();

      // trap beats branch; trap beats ret and leaves RAS intact
      trap = 1; branch_taken = 1; branch_target = 32'h40;
      step();
      st("trap_br", 32'h100, 0, 0, 1);
      idle();
      jump_valid = 1; call = 1; jump_target = 32'h900;
      step();
      st("call900", 32'h900, 0, 0, 0);
      idle();
      trap = 1; ret = 1;
      step();
      st("trap_ret", 32'h100, 0, 0, 0);
      idle();
      step();
      chk("seq104.pc", pc, 32'h104);

      // ret+call together: jump to popped 0x104, top replaced by 0x108
      ret = 1; call = 1; jump_valid = 1; jump_target = 32'hB00;
      step();
      st("ret_call", 32'h104, 0, 0, 0);
      idle();
      ret = 1;
      step();
      st("ret_swap", 32'h108, 0, 0, 1);
      idle();

      // wrap at top of address space
      jump_valid = 1; jump_target = 32'hFFFF_FFFC;
      step();
      chk("jmp_top.pc", pc, 32'hFFFF_FFFC);
      idle();
      step();
      st("wrap", 32'h0, 0, 0, 1);

      // reset mid call/ret sequence clears RAS
      jump_valid = 1; call = 1; jump_target = 32'h40;
      step();
      st("call40", 32'h40, 0, 0, 0);
      idle();
      ret = 1; reset = 1;
      step();
      st("rst_mid", 32'h0, 0, 0, 1);
      chk("rst_mid.pc_valid", {31'b0, pc_valid}, 32'd0);
      reset = 0; ret = 0;
      step();
      chk("post_rst.pc", pc, 32'h4);
      chk("post_rst.pc_valid", {31'b0, pc_valid}, 32'd1);
      ret = 1;
      step();
      st("post_rst_unf", 32'h100, 0, 1, 1);
      idle();
      step();
      st("post_rst_end", 32'h104, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
